// File: rtl/fifo2axis.sv
// fifo2axis: drains a 1-cycle-latency FIFO read port into AXI-Stream frames
// of FRAME_LEN words, with tlast on the final word of each frame. A 2-entry
// skid buffer hides the FIFO read latency so one word per cycle is sustained.
//
// Optional feature macro: FIFO2AXIS_TIMEOUT_EN
//   defined   -> a stalled partial frame is closed after TIMEOUT idle cycles
//                by emitting zero words up to and including tlast (PAD state)
//   undefined -> a partial frame waits indefinitely; padded is tied to 0
//
// Handshake: a word transfers on any rising edge where m_axis_tvalid and
// m_axis_tready are both high. tvalid is driven only from registers (never
// from tready); once raised, tvalid, tdata and tlast hold until that transfer.
module fifo2axis #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic                  padded
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef FIFO2AXIS_TIMEOUT_EN
    STREAM = 2'd1,
    PAD    = 2'd2
`else
    STREAM = 2'd1
`endif
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] skid0;     // head of the skid buffer
  logic [DATA_WIDTH-1:0] skid1;
  logic [1:0]            count;     // skid buffer occupancy, 0..2
  logic                  pending;   // a FIFO word lands in the buffer this cycle
  logic                  in_pad;
  logic                  hs;
  logic                  buf_pop;

`ifdef FIFO2AXIS_TIMEOUT_EN
  assign in_pad = (state == PAD);
`else
  assign in_pad = 1'b0;
`endif

  assign m_axis_tvalid = (count != 2'd0) | in_pad;
  assign m_axis_tdata  = in_pad ? '0 : skid0;
  assign m_axis_tlast  = (word_idx == LAST_IDX);
  assign hs            = m_axis_tvalid & m_axis_tready;
  // Padding words are synthesised, so only real transfers drain the buffer.
  assign buf_pop       = hs & ~in_pad;

  // Read ahead only while the buffer plus the in-flight word still leaves a
  // free slot after this cycle's pop; that bound makes overflow impossible.
  assign fifo_rd = ~rst & ~fifo_empty & ~in_pad &
                   (({1'b0, count} + {2'b00, pending}) < (3'd2 + {2'b00, buf_pop}));

  // Skid buffer: capture the word read last cycle, shift on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      count   <= 2'd0;
      skid0   <= '0;
      skid1   <= '0;
    end else begin
      pending <= fifo_rd;
      case ({pending, buf_pop})
        2'b10: begin
          if (count == 2'd0) skid0 <= fifo_rdata;
          else               skid1 <= fifo_rdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            skid0 <= fifo_rdata;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pending && !buf_pop && (count == 2'd2)));

`ifdef FIFO2AXIS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            stall_idle;
  logic            to_fire;

  // A frame is stalled when nothing is buffered, in flight, or available.
  assign stall_idle = (state == STREAM) && (count == 2'd0) && !pending && fifo_empty;
  assign to_fire    = stall_idle && (to_cnt == TO_LAST);

  // Count consecutive stalled cycles; any push or progress restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (stall_idle && !to_fire) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign padded = 1'b0;
`endif

  // Frame FSM: tracks word position and pulses the completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      frame_done <= 1'b0;
`ifdef FIFO2AXIS_TIMEOUT_EN
      padded     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef FIFO2AXIS_TIMEOUT_EN
      padded     <= 1'b0;
`endif
      if (hs) begin
        word_idx <= m_axis_tlast ? '0 : word_idx + 1'b1;
      end
      case (state)
        IDLE: begin
          if (hs) state <= STREAM;
        end
        STREAM: begin
          if (hs && m_axis_tlast) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
`ifdef FIFO2AXIS_TIMEOUT_EN
          else if (to_fire) begin
            state <= PAD;
          end
`endif
        end
`ifdef FIFO2AXIS_TIMEOUT_EN
        PAD: begin
          if (hs && m_axis_tlast) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            padded     <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2axis.sv
// tb_fifo2axis: directed bench for fifo2axis. A small FIFO model with
// 1-cycle read latency feeds the DUT; every handshake is checked against a
// hand-written expected queue of {pad, last, data} entries.
// Runs the timeout scenario only when FIFO2AXIS_TIMEOUT_EN is defined.
module tb_fifo2axis;
  localparam int DW = 32;
  localparam int FL = 4;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          frame_done;
  logic          padded;

  fifo2axis #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .padded        (padded)
  );

  // FIFO model: data appears on fifo_rdata the cycle after fifo_rd
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // scoreboard state
  logic [DW+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  int pd_cnt = 0;
  int max_occ = 0;
  int first_valid_cyc = -1;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int last_real_hs_cyc = -1;
  int first_pad_hs_cyc = -1;
  int load_cyc = 0;
  int bp_phase = 0;
  logic ready_bp = 1'b0;
  logic exp_fd = 1'b0;
  logic exp_pd = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic last, input logic pad);
    exp_q.push_back({pad, last, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd"}, fifo_rd, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_padded"}, padded, 0);
  endtask

  // One clock cycle: drive tready at negedge, then sample and score.
  task automatic cycle();
    logic [DW+1:0] e;
    @(negedge clk);
    if (ready_bp) begin
      m_axis_tready = (bp_phase == 0) || (bp_phase == 3);
      bp_phase = (bp_phase + 1) % 4;
    end else begin
      m_axis_tready = 1'b1;
    end
    #1;
    cyc++;
    check("frame_done", frame_done, exp_fd);
    check("padded", padded, exp_pd);
    exp_fd = 1'b0;
    exp_pd = 1'b0;
    if (prev_stall) begin
      check("stall_tvalid", m_axis_tvalid, 1);
      check("stall_tdata", m_axis_tdata, prev_data);
      check("stall_tlast", m_axis_tlast, prev_last);
    end
    if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      hs_cnt++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e[DW-1:0]);
        check("tlast", m_axis_tlast, e[DW]);
        exp_fd = e[DW];
        exp_pd = e[DW] & e[DW+1];
        if (e[DW+1]) begin
          if (first_pad_hs_cyc < 0) first_pad_hs_cyc = cyc;
        end else begin
          last_real_hs_cyc = cyc;
        end
      end
    end
    if (frame_done) fd_cnt++;
    if (padded) pd_cnt++;
    prev_stall = m_axis_tvalid & ~m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (int'(dut.count) > max_occ) max_occ = int'(dut.count);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    cycle();
    cycle();
  endtask

  initial begin
    int fd0;
    int pd0;
    int h0;
    int n;
    rst = 1'b1;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Continuous stream of 8 words, tready held high
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h11 + i));
    expect_word(32'h11, 0, 0); expect_word(32'h12, 0, 0);
    expect_word(32'h13, 0, 0); expect_word(32'h14, 1, 0);
    expect_word(32'h15, 0, 0); expect_word(32'h16, 0, 0);
    expect_word(32'h17, 0, 0); expect_word(32'h18, 1, 0);
    load_cyc = cyc;
    first_valid_cyc = -1;
    first_hs_cyc = -1;
    #1;
    check("t1_rd_after_load", fifo_rd, 1);
    drain("t1_drain", 40);
    check("t1_latency", first_valid_cyc - load_cyc, 2);
    check("t1_first_hs", first_hs_cyc - first_valid_cyc, 0);
    check("t1_throughput", last_hs_cyc - first_hs_cyc, 7);
    check("t1_frames", fd_cnt - fd0, 2);

    // Backpressure: tready 1,0,0,1 repeating
    fd0 = fd_cnt;
    ready_bp = 1'b1;
    bp_phase = 0;
    max_occ = 0;
    for (int i = 0; i < 4; i++) push_word(DW'(32'h11 + i));
    expect_word(32'h11, 0, 0); expect_word(32'h12, 0, 0);
    expect_word(32'h13, 0, 0); expect_word(32'h14, 1, 0);
    drain("t2_drain", 60);
    ready_bp = 1'b0;
    check("t2_max_occ_le2", max_occ <= 2, 1);
    check("t2_frames", fd_cnt - fd0, 1);

    // FIFO underrun: 2 words, a gap, then 2 more words
    fd0 = fd_cnt;
    pd0 = pd_cnt;
    push_word(32'h21); push_word(32'h22);
    expect_word(32'h21, 0, 0); expect_word(32'h22, 0, 0);
    repeat (8) cycle();
    check("t3_gap_tvalid", m_axis_tvalid, 0);
    check("t3_gap_tlast", m_axis_tlast, 0);
    check("t3_gap_frames", fd_cnt - fd0, 0);
    push_word(32'h23); push_word(32'h24);
    expect_word(32'h23, 0, 0); expect_word(32'h24, 1, 0);
    drain("t3_drain", 40);
    check("t3_frames", fd_cnt - fd0, 1);
    check("t3_no_pad", pd_cnt - pd0, 0);

`ifdef FIFO2AXIS_TIMEOUT_EN
    // Timeout: 2 words then FIFO stays empty; frame is closed with zeros
    fd0 = fd_cnt;
    pd0 = pd_cnt;
    first_pad_hs_cyc = -1;
    push_word(32'hA1); push_word(32'hA2);
    expect_word(32'hA1, 0, 0); expect_word(32'hA2, 0, 0);
    expect_word(32'h0, 0, 1); expect_word(32'h0, 1, 1);
    drain("t4_drain", 80);
    check("t4_pad_delay", first_pad_hs_cyc - last_real_hs_cyc, TO + 1);
    check("t4_padded", pd_cnt - pd0, 1);
    check("t4_frames", fd_cnt - fd0, 1);
`endif

    // Reset mid-frame after 2 of 4 handshakes. At that point 0x43 is in
    // flight (lost) and 0x44 is still in the FIFO: its read is suppressed
    // because rst forces fifo_rd low before the edge.
    push_word(32'h41); push_word(32'h42); push_word(32'h43); push_word(32'h44);
    expect_word(32'h41, 0, 0); expect_word(32'h42, 0, 0);
    expect_word(32'h43, 0, 0); expect_word(32'h44, 1, 0);
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt - h0 < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t5_two_hs", hs_cnt - h0, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_reset");
    exp_q.delete();
    exp_fd = 1'b0;
    exp_pd = 1'b0;
    prev_stall = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    check("t5_residual_word", fifo_empty, 0);
    fd0 = fd_cnt;
    push_word(32'h51); push_word(32'h52); push_word(32'h53);
    expect_word(32'h44, 0, 0); expect_word(32'h51, 0, 0);
    expect_word(32'h52, 0, 0); expect_word(32'h53, 1, 0);
    drain("t5_drain", 40);
    check("t5_frames", fd_cnt - fd0, 1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo2axis.md
# fifo2axis

Drain stage downstream of the stream-to-FIFO collector. It pulls words from a 1-cycle-latency FIFO read port and re-emits them as AXI-Stream frames of FRAME_LEN words, with tlast on the final word of each frame. A 2-entry skid buffer decouples FIFO read latency from downstream tready, so the block sustains one word per cycle. It is the egress point of the buffered path toward the next AXI-Stream consumer.

## Interface
- DATA_WIDTH, 32, word width of FIFO data and tdata
- FRAME_LEN, 4, words per frame (≥2)
- TIMEOUT, 16, idle cycles before pad-and-close (only with macro; ≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd
- fifo_empty  in  1  FIFO has no words
- fifo_rd  out  1  FIFO read strobe, one word per asserted cycle
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last word of frame
- frame_done  out  1  one-cycle pulse after the tlast handshake
- padded  out  1  one-cycle pulse after a padded tlast handshake; constant 0 without macro

## Operation
- Reset values: fifo_rd 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, frame_done 0, padded 0, buffer empty, word_idx 0, pending 0, state IDLE.
- fifo_rd is combinational: it is asserted when !fifo_empty, state != PAD, and (count + pending − pop) < 2. Here count is the buffer occupancy (0..2), pending is the registered fifo_rd from the previous cycle, and pop = m_axis_tvalid & m_axis_tready. While rst is high, fifo_rd is 0.
- When pending=1, fifo_rdata is written into the buffer tail at the clock edge. The buffer never overflows; an overflow is an assertion failure.
- m_axis_tvalid = (count>0) or state==PAD. m_axis_tdata is the buffer head, or 0 in PAD.
- m_axis_tlast = (word_idx == FRAME_LEN−1).
- word_idx is $clog2(FRAME_LEN) bits wide. It increments on each handshake and wraps to 0 after tlast.
- AXI rules:
  - tdata, tlast, and tvalid hold stable while tvalid & !tready.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- States:
  - IDLE: word_idx==0. The first handshake moves to STREAM.
  - STREAM: the handshake with tlast returns to IDLE and pulses frame_done.
  - PAD (macro only): emits zero words until the tlast handshake, then returns to IDLE and pulses frame_done and padded.
- Simultaneous push and pop in one cycle leaves count unchanged.
- Reset mid-frame discards buffered words and the partial frame. A FIFO word in flight at reset is lost.

## Timing
- Read-to-valid latency: fifo_rd high in cycle N, data captured at the end of N+1, m_axis_tvalid high in N+2.
- Throughput: one word per cycle with tready held 1 and FIFO non-empty.
- After tready deasserts, at most 2 words in buffer plus 0 pending; fifo_rd stays low until a pop.
- frame_done and padded assert in the cycle following the handshake, for exactly 1 cycle.
- Timeout counter (macro only):
  - Counts cycles in STREAM with count==0, pending==0, and fifo_empty.
  - Clears on any push.
  - Reaching TIMEOUT moves to PAD on the next edge.
  - A FIFO word arriving while in PAD is read only after returning to IDLE and becomes word 0 of the next frame.

## Configuration
- FIFO2AXIS_TIMEOUT_EN defined: the timeout counter and PAD state are present, and stalled partial frames are closed with zero words plus tlast.
- Undefined: no counter and no PAD state, padded tied to 0, and a partial frame waits indefinitely for more FIFO data.

## Test plan
- Continuous stream: FIFO preloaded with 8 words 0x11..0x18, tready=1. Expect valid from cycle 2 after the first fifo_rd, 8 consecutive handshakes, tlast on 0x14 and 0x18, frame_done pulsed twice.
- Backpressure: tready toggles 1,0,0,1 repeatedly with 4 words. Expect tdata stable during stalls, count never above 2, data order 0x11..0x14 intact.
- FIFO underrun: 2 words, then 5 empty cycles, then 2 words, with the macro off. Expect a single frame with tlast on the 4th word and no padding.
- Timeout (macro on, TIMEOUT=16): 2 words 0xA1 and 0xA2, then the FIFO stays empty. After 16 idle cycles, emit 0x00 and 0x00 with tlast on the second, and pulse padded.
- Reset mid-frame: assert rst after 2 of 4 words have handshaken. Expect all outputs at reset values immediately. The next word forms word 0 of a new frame, with tlast on the 4th word after reset.
